edit_sequencer: RTL and testbench

EDIT_SEQUENCER -- requirements
Module: edit_sequencer

---
 rtl/edit_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_edit_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/edit_sequencer.sv
// edit_sequencer: turns raw push-buttons into single-cycle increment/decrement
// pulses for time, date and alarm editing. One button is tracked at a time:
// debounce, first pulse, hold delay, then auto-repeat until release.
module edit_sequencer #(
  parameter int DEBOUNCE_CYC = 10000,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] buttons,
  input  logic [2:0] switches,
  output logic [1:0] mode,
  output logic [3:0] t_inc,
  output logic [2:0] t_dec,
  output logic [2:0] dt_inc,
  output logic [2:0] dt_dec,
  output logic [2:0] al_inc,
  output logic [1:0] al_dec,
  output logic       busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DEBOUNCE = 3'd1;
  localparam logic [2:0] S_HOLD     = 3'd2;
  localparam logic [2:0] S_REPEAT   = 3'd3;
  localparam logic [2:0] S_WAIT_REL = 3'd4;

  // Terminal counts; compared with >= so a counter can never run past them.
  localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYC - 1);
  localparam logic [19:0] DLY_LAST = 20'(REPEAT_DELAY - 1);
  localparam logic [19:0] RPT_LAST = 20'(REPEAT_RATE - 1);

  // Flat pulse vector layout:
  // [3:0] t_inc, [6:4] t_dec, [9:7] dt_inc, [12:10] dt_dec,
  // [15:13] al_inc, [17:16] al_dec
  function automatic logic [17:0] map_pulse(input logic [1:0] m, input logic [2:0] b);
    logic [17:0] v;
    v = '0;
    case (m)
      2'b01: begin
        case (b)
          3'd0: v[3]  = 1'b1;
          3'd1: v[2]  = 1'b1;
          3'd5: v[6]  = 1'b1;
          3'd2: v[1]  = 1'b1;
          3'd6: v[5]  = 1'b1;
          3'd3: v[0]  = 1'b1;
          3'd7: v[4]  = 1'b1;
          default: v = '0;
        endcase
      end
      2'b10: begin
        case (b)
          3'd1: v[9]  = 1'b1;
          3'd5: v[12] = 1'b1;
          3'd2: v[8]  = 1'b1;
          3'd6: v[11] = 1'b1;
          3'd3: v[7]  = 1'b1;
          3'd7: v[10] = 1'b1;
          default: v = '0;
        endcase
      end
      2'b11: begin
        case (b)
          3'd0: v[15] = 1'b1;
          3'd1: v[14] = 1'b1;
          3'd5: v[17] = 1'b1;
          3'd2: v[13] = 1'b1;
          3'd6: v[16] = 1'b1;
          default: v = '0;
        endcase
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Arbitration order: b0, b1, b5, b2, b6, b3, b7.
  function automatic logic [2:0] prio_btn(input int i);
    case (i)
      0:       return 3'd0;
      1:       return 3'd1;
      2:       return 3'd5;
      3:       return 3'd2;
      4:       return 3'd6;
      5:       return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  logic [7:0]  b_meta_q, b_sync_q;
  logic [1:0]  mode_q, mode_d;
  logic [2:0]  state_q, state_d;
  logic [2:0]  btn_q, btn_d;
  logic [19:0] cnt_q, cnt_d, cnt_inc;
  logic [17:0] pulse_q, pulse_d;
  logic [7:0]  mapped_mask;
  logic        cand_valid;
  logic [2:0]  cand_idx;
  logic        mode_chg;
  logic        trk_high;
  logic        fire;

  // Which buttons have a function in the current mode.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign mapped_mask[gi] = |map_pulse(mode_q, 3'(gi));
    end
  endgenerate

  // Two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_meta_q <= '0;
      b_sync_q <= '0;
    end else begin
      b_meta_q <= buttons;
      b_sync_q <= b_meta_q;
    end
  end

  // Mode decode from switches, [0] has highest priority.
  always_comb begin
    mode_d = 2'b00;
    if (switches[0])      mode_d = 2'b01;
    else if (switches[1]) mode_d = 2'b10;
    else if (switches[2]) mode_d = 2'b11;
  end

  // Pick the highest-priority pressed button that is mapped in this mode.
  always_comb begin
    cand_valid = 1'b0;
    cand_idx   = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (b_sync_q[prio_btn(i)] && mapped_mask[prio_btn(i)]) begin
        cand_valid = 1'b1;
        cand_idx   = prio_btn(i);
      end
    end
  end

  assign cnt_inc  = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;
  assign mode_chg = (mode_d != mode_q);
  assign trk_high = b_sync_q[btn_q];

  // Next-state logic: a mode change abandons the press, release returns to idle.
  always_comb begin
    state_d = state_q;
    btn_d   = btn_q;
    cnt_d   = cnt_inc;
    fire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cand_valid) begin
          state_d = S_DEBOUNCE;
          btn_d   = cand_idx;
        end
      end
      S_DEBOUNCE: begin
        if (mode_chg) begin
          state_d = S_WAIT_REL;
          cnt_d   = '0;
        end else if (!trk_high) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          fire    = 1'b1;
        end
      end
      S_HOLD: begin
        if (mode_chg) begin
          state_d = S_WAIT_REL;
          cnt_d   = '0;
        end else if (!trk_high) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DLY_LAST) begin
          state_d = S_REPEAT;
          cnt_d   = '0;
          fire    = 1'b1;
        end
      end
      S_REPEAT: begin
        if (mode_chg) begin
          state_d = S_WAIT_REL;
          cnt_d   = '0;
        end else if (!trk_high) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= RPT_LAST) begin
          cnt_d   = '0;
          fire    = 1'b1;
        end
      end
      S_WAIT_REL: begin
        cnt_d = '0;
        if (b_sync_q == 8'h00) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    pulse_d = fire ? map_pulse(mode_q, btn_q) : '0;
  end

  // Mode, FSM, counter and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q  <= 2'b00;
      state_q <= S_IDLE;
      btn_q   <= 3'd0;
      cnt_q   <= '0;
      pulse_q <= '0;
    end else begin
      mode_q  <= mode_d;
      state_q <= state_d;
      btn_q   <= btn_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign mode   = mode_q;
  assign busy   = (state_q != S_IDLE);
  assign t_inc  = pulse_q[3:0];
  assign t_dec  = pulse_q[6:4];
  assign dt_inc = pulse_q[9:7];
  assign dt_dec = pulse_q[12:10];
  assign al_inc = pulse_q[15:13];
  assign al_dec = pulse_q[17:16];

endmodule

// File: tb/tb_edit_sequencer.sv
// Bench for edit_sequencer: a schedule-based model predicts every output each
// cycle, and directed scenarios pin pulse counts and timing with literals.
module tb_edit_sequencer;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] buttons = '0;
  logic [2:0] switches = '0;
  logic [1:0] mode;
  logic [3:0] t_inc;
  logic [2:0] t_dec, dt_inc, dt_dec, al_inc;
  logic [1:0] al_dec;
  logic       busy;

  edit_sequencer #(.DEBOUNCE_CYC(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .switches(switches), .mode(mode),
    .t_inc(t_inc), .t_dec(t_dec), .dt_inc(dt_inc), .dt_dec(dt_dec),
    .al_inc(al_inc), .al_dec(al_dec), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [17:0] dut_vec;
  assign dut_vec = {al_dec, al_inc, dt_dec, dt_inc, t_dec, t_inc};

  int checks = 0;
  int errors = 0;

  // Output bit for each (mode, button); -1 means unmapped.
  int tbl [4][8] = '{
    '{-1, -1, -1, -1, -1, -1, -1, -1},
    '{ 3,  2,  1,  0, -1,  6,  5,  4},
    '{-1,  9,  8,  7, -1, 12, 11, 10},
    '{15, 14, 13, -1, -1, 17, 16, -1}
  };
  int prio [7] = '{0, 1, 5, 2, 6, 3, 7};

  // Model state: tracked button and the absolute edge of its next pulse.
  logic [7:0]  m_s1 = '0, m_sync = '0;
  logic [1:0]  m_mode = '0;
  bit          m_trk = 0, m_wait = 0;
  int          m_btn = 0, m_np = 0;
  longint      m_edge = 0, m_next = 0;
  logic [17:0] m_pulse = '0;

  function automatic logic [1:0] sw_to_mode(input logic [2:0] s);
    if (s[0]) return 2'b01;
    if (s[1]) return 2'b10;
    if (s[2]) return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 = '0; m_sync = '0; m_mode = '0; m_trk = 0; m_wait = 0;
      m_pulse = '0;
    end else begin
      logic [1:0] sm;
      bit found;
      m_edge++;
      m_pulse = '0;
      sm = sw_to_mode(switches);
      if (m_wait) begin
        if (m_sync == 8'h00) m_wait = 0;
      end else if (m_trk) begin
        if (sm != m_mode) begin
          m_trk = 0; m_wait = 1;
        end else if (!m_sync[m_btn]) begin
          m_trk = 0;
        end else if (m_edge == m_next) begin
          m_pulse = 18'(1) << tbl[m_mode][m_btn];
          m_next  = m_edge + ((m_np == 0) ? RD : RR);
          m_np++;
        end
      end else begin
        found = 0;
        for (int k = 0; k < 7; k++) begin
          if (!found && m_sync[prio[k]] && tbl[m_mode][prio[k]] >= 0) begin
            found = 1; m_trk = 1; m_btn = prio[k];
            m_next = m_edge + DEB; m_np = 0;
          end
        end
      end
      m_sync = m_s1;
      m_s1   = buttons;
      m_mode = sm;
    end
  end

  // Cycle-by-cycle comparison against the model.
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_vec !== m_pulse || mode !== m_mode || busy !== (m_trk || m_wait)) begin
        errors++;
        $display("FAIL model t=%0t pulses=%h/%h mode=%0d/%0d busy=%0b/%0b", $time,
                 dut_vec, m_pulse, mode, m_mode, busy, (m_trk || m_wait));
      end
    end
  end

  // Pulse monitor used by the literal checks.
  int          cyc = 0;
  int          press_cyc = 0;
  int          mon_cnt = 0, mon_first = -1, mon_last = -1;
  logic [17:0] mon_or = '0;
  bit          busy_seen = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dut_vec != 0) begin
      mon_cnt++;
      mon_or |= dut_vec;
      if (mon_first < 0) mon_first = cyc - press_cyc;
      mon_last = cyc - press_cyc;
    end
    if (busy) busy_seen = 1;
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clr_mon();
    mon_cnt = 0; mon_first = -1; mon_last = -1; mon_or = '0; busy_seen = 0;
    press_cyc = cyc + 1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  initial begin
    #3 rst = 1'b0;
    #1 chk_en = 1;
    step(2);
    chk("reset_pulses", int'(dut_vec), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_mode", int'(mode), 0);
    rst = 1'b1;

    // Short press in time mode: no pulse.
    switches = 3'b001; step(2);
    clr_mon(); buttons = 8'h02; step(3); buttons = 8'h00; step(8);
    chk("short_press_pulses", mon_cnt, 0);
    chk("short_press_busy_seen", int'(busy_seen), 1);
    chk("short_press_busy_end", int'(busy), 0);

    // Long press of b1: 6 hour+ pulses at offsets 6, 26, 34, 42, 50, 58.
    clr_mon(); buttons = 8'h02; step(60); buttons = 8'h00; step(8);
    chk("hold_count", mon_cnt, 6);
    chk("hold_first", mon_first, 6);
    chk("hold_last", mon_last, 58);
    chk("hold_bits", int'(mon_or), 32'h4);
    chk("hold_busy_end", int'(busy), 0);

    // Date mode, b2 and b6 together: only month+ fires.
    switches = 3'b010; step(2);
    clr_mon(); buttons = 8'h44; step(10); buttons = 8'h00; step(6);
    chk("date_pair_count", mon_cnt, 1);
    chk("date_pair_bits", int'(mon_or), 32'h100);

    // Alarm mode, b3 is unmapped: nothing happens.
    switches = 3'b100; step(2);
    clr_mon(); buttons = 8'h08; step(20);
    chk("alarm_b3_pulses", mon_cnt, 0);
    chk("alarm_b3_busy_seen", int'(busy_seen), 0);
    buttons = 8'h00; step(4);

    // Time mode b7 into repeat, then switch to display on a pulse edge.
    switches = 3'b001; step(2);
    clr_mon(); buttons = 8'h80; step(34);
    chk("mode_chg_pre_count", mon_cnt, 2);
    switches = 3'b000; step(20);
    chk("mode_chg_post_count", mon_cnt, 2);
    chk("mode_chg_bits", int'(mon_or), 32'h10);
    chk("mode_chg_mode", int'(mode), 0);
    chk("mode_chg_wait_busy", int'(busy), 1);
    buttons = 8'h00; step(1);
    chk("release_busy_1", int'(busy), 1);
    step(3);
    chk("release_busy_4", int'(busy), 0);

    // Reset during HOLD, button still held afterwards.
    switches = 3'b001; step(2);
    clr_mon(); buttons = 8'h02; step(10);
    chk("pre_rst_count", mon_cnt, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_mode", int'(mode), 0);
    chk("async_rst_pulses", int'(dut_vec), 0);
    step(3);
    rst = 1'b1; clr_mon(); step(12);
    chk("post_rst_first", mon_first, 6);
    chk("post_rst_count", mon_cnt, 1);
    buttons = 8'h00; step(6);
    chk("post_rst_busy_end", int'(busy), 0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
